// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end scheduler: opcodes, FSM encoding, default widths.
package alu_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned OP_W        = 2;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
    localparam op_t OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_WAIT    = 2'b10,
        S_RESPOND = 2'b11
    } sched_state_t;

    // A divide with a zero divisor is answered locally and never reaches the ALU.
    function automatic logic is_div_by_zero(input op_t op, input logic b_is_zero);
        return (op == OP_DIV) && b_is_zero;
    endfunction

endpackage

// File: rtl/alu_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic ptr_q;

    // Pointer side first, the other side only if the pointer side is idle.
    always_comb begin
        grant_c = 2'b00;
        if (ptr_q == 1'b0) begin
            if (req[0]) begin
                grant_c = 2'b01;
            end else if (req[1]) begin
                grant_c = 2'b10;
            end
        end else begin
            if (req[1]) begin
                grant_c = 2'b10;
            end else if (req[0]) begin
                grant_c = 2'b01;
            end
        end
    end

    // After an accept the pointer moves to the requester that lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (accept && (grant_c != 2'b00)) begin
            ptr_q <= grant_c[0];
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU between two requesters: arbitrate, issue, wait with timeout, respond.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_op,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_op,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,

    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_result,
    output logic                 rsp0_error,

    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_result,
    output logic                 rsp1_error,

    output logic                 alu_start,
    output logic [1:0]           alu_opcode,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic                 alu_done,
    input  logic [2*WIDTH-1:0]   alu_result,

    output logic                 busy
);

    localparam int unsigned RES_W   = 2 * WIDTH;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

    sched_state_t        state_q, state_d;
    logic                owner_q, owner_d;
    op_t                 op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                error_q, error_d;
    logic                start_q, start_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic                busy_q, busy_d;

    logic [1:0]          req_c;
    logic [1:0]          grant_c;
    logic                accept_c;
    logic                owner_ready_c;
    op_t                 sel_op_c;
    logic [WIDTH-1:0]    sel_a_c;
    logic [WIDTH-1:0]    sel_b_c;

    // Requests are only visible to the arbiter while idle, so ready is low elsewhere.
    assign req_c    = {req1_valid, req0_valid} & {2{state_q == S_IDLE}};
    assign accept_c = |grant_c;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_c),
        .accept  (accept_c),
        .grant_c (grant_c)
    );

    assign req0_ready = grant_c[0];
    assign req1_ready = grant_c[1];

    assign sel_op_c      = grant_c[1] ? op_t'(req1_op) : op_t'(req0_op);
    assign sel_a_c       = grant_c[1] ? req1_a : req0_a;
    assign sel_b_c       = grant_c[1] ? req1_b : req0_b;
    assign owner_ready_c = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state and next-register values.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        timer_d  = timer_q;
        result_d = result_q;
        error_d  = error_q;
        start_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    owner_d = grant_c[1];
                    op_d    = sel_op_c;
                    a_d     = sel_a_c;
                    b_d     = sel_b_c;
                    if (is_div_by_zero(sel_op_c, sel_b_c == '0)) begin
                        result_d = '0;
                        error_d  = 1'b1;
                        state_d  = S_RESPOND;
                    end else begin
                        start_d  = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the timeout cycle still counts as success.
                if (alu_done) begin
                    result_d = alu_result;
                    error_d  = 1'b0;
                    state_d  = S_RESPOND;
                end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    state_d  = S_RESPOND;
                end else begin
                    timer_d  = timer_q + TIMER_W'(1);
                end
            end
            S_RESPOND: begin
                if (owner_ready_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rsp0_valid_d = (state_d == S_RESPOND) && (owner_d == 1'b0);
        rsp1_valid_d = (state_d == S_RESPOND) && (owner_d == 1'b1);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            timer_q      <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            start_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            timer_q      <= timer_d;
            result_q     <= result_d;
            error_q      <= error_d;
            start_q      <= start_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Only the owner's valid is raised, so both channels can share the payload registers.
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_error  = error_q;
    assign rsp1_error  = error_q;
    assign alu_start   = start_q;
    assign alu_opcode  = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU stub of programmable latency.
module tb_alu_scheduler;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
    logic [7:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [15:0]  rsp0_result, rsp1_result;
    logic         rsp0_error, rsp1_error;
    logic         alu_start;
    logic [1:0]   alu_opcode;
    logic [7:0]   alu_a, alu_b;
    logic         alu_done;
    logic [15:0]  alu_result;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int stub_lat = 3;
    bit stub_hang = 1'b0;
    int stub_cnt;

    always #5 clk = ~clk;

    alu_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_error(rsp0_error),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_error(rsp1_error),
        .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        case (op)
            2'b00:   return {8'h00, a} + {8'h00, b};
            2'b01:   return {8'h00, a} - {8'h00, b};
            2'b10:   return {8'h00, a} * {8'h00, b};
            default: return (b == 8'h00) ? 16'h0000 : {a % b, a / b};
        endcase
    endfunction

    // ALU stub: done pulses stub_lat cycles after it sees alu_start, unless hung.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
            stub_cnt   <= 0;
        end else begin
            alu_done <= 1'b0;
            if (alu_start) begin
                stub_cnt <= stub_lat;
            end else if (stub_cnt > 1) begin
                stub_cnt <= stub_cnt - 1;
            end else if (stub_cnt == 1 && !stub_hang) begin
                alu_done   <= 1'b1;
                alu_result <= alu_model(alu_opcode, alu_a, alu_b);
                stub_cnt   <= 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic ack(input int ch);
        if (ch == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    // Waits up to budget negedges for the channel's rsp_valid; cyc == budget means it never came.
    task automatic wait_rsp(input int ch, input int budget, output int cyc, output int starts,
                            output int other);
        cyc = 0; starts = 0; other = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (alu_start === 1'b1) starts++;
            if ((ch == 0 ? rsp1_valid : rsp0_valid) === 1'b1) other++;
            if ((ch == 0 ? rsp0_valid : rsp1_valid) === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst_n = 1'b0;
        tick();
        flags = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error,
                 alu_start, busy};
        tests++;
        if (flags !== 8'h00) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000000", flags);
        end
        tests++;
        if (rsp0_result !== 16'h0 || rsp1_result !== 16'h0) begin
            fails++; $display("FAIL reset_result: got %h/%h expected 0000/0000", rsp0_result, rsp1_result);
        end
        tests++;
        if (alu_opcode !== 2'b00 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            fails++; $display("FAIL reset_alu_bus: got op=%b a=%h b=%h expected zeros", alu_opcode, alu_a, alu_b);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_add();
        int cyc, starts, other;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd25; req0_b = 8'd17;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++; $display("FAIL add_ready: got %b expected 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        tests++;
        if ({alu_start, busy} !== 2'b11 || alu_opcode !== 2'b00 || alu_a !== 8'd25 || alu_b !== 8'd17) begin
            fails++; $display("FAIL add_issue: got start=%b busy=%b op=%b a=%0d b=%0d expected 1 1 00 25 17",
                              alu_start, busy, alu_opcode, alu_a, alu_b);
        end
        wait_rsp(0, 100, cyc, starts, other);
        // done raised stub_lat edges after start falls, response one edge later
        tests++;
        if (cyc !== 5) begin
            fails++; $display("FAIL add_latency: got %0d cycles expected 5", cyc);
        end
        tests++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 16'd42 || rsp0_error !== 1'b0) begin
            fails++; $display("FAIL add_rsp: got v=%b r=%0d e=%b expected 1 42 0", rsp0_valid, rsp0_result, rsp0_error);
        end
        tests++;
        if (starts !== 0 || other !== 0) begin
            fails++; $display("FAIL add_extra: got starts=%0d rsp1_valid=%0d expected 0 0", starts, other);
        end
        ack(0);
        tests++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL add_release: got v=%b busy=%b expected 0 0", rsp0_valid, busy);
        end
    endtask

    task automatic test_concurrent();
        int cyc, starts, other;
        int w;
        logic [15:0] exp_res;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            w = r % 2;
            exp_res = (w == 0) ? 16'd15 : 16'd63;
            req0_valid = 1'b1; req0_op = 2'b10; req0_a = 8'd3; req0_b = 8'd5;
            req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'd7; req1_b = 8'd9;
            #1;
            tests++;
            if ({req1_ready, req0_ready} !== ((w == 0) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL rr_grant[%0d]: got %b expected winner %0d", r, {req1_ready, req0_ready}, w);
            end
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_rsp(w, 100, cyc, starts, other);
            tests++;
            if ((w == 0 ? rsp0_result : rsp1_result) !== exp_res || other !== 0 ||
                (w == 0 ? rsp0_valid : rsp1_valid) !== 1'b1) begin
                fails++; $display("FAIL rr_result[%0d]: got %0d (other=%0d) expected %0d", r,
                                  (w == 0 ? rsp0_result : rsp1_result), other, exp_res);
            end
            ack(w);
        end
    endtask

    task automatic test_div();
        int cyc, starts, other;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 8'd100; req1_b = 8'd0;
        #1;
        tests++;
        if (req1_ready !== 1'b1) begin
            fails++; $display("FAIL div0_ready: got %b expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        tests++;
        if (rsp1_valid !== 1'b1 || alu_start !== 1'b0 || rsp1_result !== 16'h0 || rsp1_error !== 1'b1 ||
            rsp0_valid !== 1'b0) begin
            fails++; $display("FAIL div0_rsp: got v=%b start=%b r=%h e=%b v0=%b expected 1 0 0000 1 0",
                              rsp1_valid, alu_start, rsp1_result, rsp1_error, rsp0_valid);
        end
        ack(1);
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 8'd100; req1_b = 8'd7;
        tick();
        req1_valid = 1'b0;
        wait_rsp(1, 100, cyc, starts, other);
        tests++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 16'h020E || rsp1_error !== 1'b0) begin
            fails++; $display("FAIL div_rsp: got v=%b r=%h e=%b expected 1 020e 0", rsp1_valid, rsp1_result, rsp1_error);
        end
        ack(1);
    endtask

    task automatic test_timeout();
        int cyc, starts, other;
        stub_hang = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd1; req0_b = 8'd1;
        tick();
        req0_valid = 1'b0;
        tests++;
        if (alu_start !== 1'b1) begin
            fails++; $display("FAIL to_start: got %b expected 1", alu_start);
        end
        wait_rsp(0, 200, cyc, starts, other);
        // one cycle to the fall of alu_start, then TIMEOUT+1 cycles of WAIT
        tests++;
        if (cyc !== int'(TIMEOUT) + 2) begin
            fails++; $display("FAIL to_latency: got %0d cycles expected %0d", cyc, TIMEOUT + 2);
        end
        tests++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0 || rsp0_error !== 1'b1 || starts !== 0) begin
            fails++; $display("FAIL to_rsp: got v=%b r=%h e=%b starts=%0d expected 1 0000 1 0",
                              rsp0_valid, rsp0_result, rsp0_error, starts);
        end
        ack(0);
        stub_hang = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL to_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc, starts, other;
        int bad;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd200; req0_b = 8'd100;
        tick();
        req0_valid = 1'b0;
        wait_rsp(0, 100, cyc, starts, other);
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'd1; req1_b = 8'd2;
        bad = 0;
        repeat (10) begin
            tick();
            if (rsp0_valid !== 1'b1 || rsp0_result !== 16'd300 || req1_ready !== 1'b0 || rsp1_valid !== 1'b0)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL bp_hold: got %0d bad cycles (r=%0d) expected 0 and result 300", bad, rsp0_result);
        end
        ack(0);
        tests++;
        if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: got v0=%b ready1=%b expected 0 1", rsp0_valid, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        wait_rsp(1, 100, cyc, starts, other);
        tests++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 16'd3 || rsp1_error !== 1'b0) begin
            fails++; $display("FAIL bp_next: got v=%b r=%0d e=%b expected 1 3 0", rsp1_valid, rsp1_result, rsp1_error);
        end
        ack(1);
    endtask

    task automatic test_reset_mid();
        int cyc, starts, other;
        int seen;
        logic [7:0] flags;
        stub_lat = 20;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'd50; req0_b = 8'd8;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        flags = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error, alu_start, busy};
        tests++;
        if (flags !== 8'h00 || alu_opcode !== 2'b00 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            fails++; $display("FAIL rst_mid_outputs: got flags=%b op=%b a=%h b=%h expected zeros",
                              flags, alu_opcode, alu_a, alu_b);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        stub_lat = 3;
        seen = 0;
        repeat (30) begin
            tick();
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++; $display("FAIL rst_mid_dropped: got %0d active cycles expected 0", seen);
        end
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'd50; req0_b = 8'd8;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'd1;  req1_b = 8'd1;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++; $display("FAIL rst_mid_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(0, 100, cyc, starts, other);
        tests++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 16'd42 || rsp0_error !== 1'b0) begin
            fails++; $display("FAIL rst_mid_next: got v=%b r=%0d e=%b expected 1 42 0", rsp0_valid, rsp0_result, rsp0_error);
        end
        ack(0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_concurrent();
        test_div();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
